// File: rtl/spi_cmd_receiver_pkg.sv
// Shared constants for the SPI command receiver: frame layout, opcodes and FSM encodings.
// States are plain localparams so legacy code that compares raw state values keeps working.
package spi_cmd_receiver_pkg;

   localparam int FRAME_BITS_DEF = 8;
   localparam int DUTY_W         = 3;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_DUTY = 2'b01;
   localparam logic [1:0] OP_EN   = 2'b10;
   localparam logic [1:0] OP_RSVD = 2'b11;

   localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
   localparam logic [1:0] ST_IDLE      = 2'd1;
   localparam logic [1:0] ST_SHIFT     = 2'd2;
   localparam logic [1:0] ST_CHECK     = 2'd3;

   function automatic logic op_is_legal(input logic [1:0] op);
      return op != OP_RSVD;
   endfunction

endpackage

// File: rtl/spi_cmd_receiver_if.sv
// SPI pin bundle between the ESP8266 master and the command receiver.
interface spi_cmd_receiver_if;

   logic spi_sclk;
   logic spi_mosi;
   logic spi_cs_n;

   modport master (output spi_sclk, output spi_mosi, output spi_cs_n);
   modport slave  (input  spi_sclk, input  spi_mosi, input  spi_cs_n);

endinterface

// File: rtl/spi_cmd_receiver_sync_edge_det.sv
// Two-flop synchronizer followed by a registered rise/fall detector for one async SPI pin.
// level, rise and fall all update on the same edge, three clk after the pin moves.
module spi_cmd_receiver_sync_edge_det #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta;
   logic sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta   <= RESET_VAL;
         sync_q <= RESET_VAL;
         level  <= RESET_VAL;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         meta   <= din;
         sync_q <= meta;
         level  <= sync_q;
         rise   <= sync_q & ~level;
         fall   <= ~sync_q & level;
      end
   end

endmodule

// File: rtl/spi_cmd_receiver.sv
// SPI-slave command front end: shifts in 8-bit frames, decodes them into PWM duty/enable,
// counts rejected frames and stretches each accepted frame into a visible LED pulse.
module spi_cmd_receiver
   import spi_cmd_receiver_pkg::*;
#(
   parameter int FRAME_BITS   = FRAME_BITS_DEF,
   parameter int BLINK_CYCLES = 100000,
   parameter int ERR_W        = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   spi_cmd_receiver_if.slave    spi,
   output logic [DUTY_W-1:0]    duty,
   output logic                 pwm_en,
   output logic                 data_received,
   output logic                 frame_err,
   output logic [ERR_W-1:0]     err_count,
   output logic                 led_rx
);

   localparam int CNT_W   = $clog2(FRAME_BITS + 2);
   localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);
   localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0]   CNT_MAX    = CNT_W'(FRAME_BITS + 1);
   localparam logic [BLINK_W-1:0] BLINK_LOAD = BLINK_W'(BLINK_CYCLES - 1);

   logic sclk_level_unused, sclk_rise, sclk_fall_unused;
   logic cs_level, cs_rise, cs_fall;
   logic mosi_level, mosi_rise_unused, mosi_fall_unused;

   logic [1:0]            state;
   logic [1:0]            settle_cnt;
   logic [FRAME_BITS-1:0] shift_reg;
   logic [CNT_W-1:0]      bit_cnt;
   logic [BLINK_W-1:0]    blink_cnt;

   logic [1:0]                     opcode;
   logic [FRAME_BITS-3-DUTY_W:0]   payload_unused;
   logic                           frame_ok;
   logic                           commit;
   logic                           reject;

   spi_cmd_receiver_sync_edge_det #(.RESET_VAL(1'b0)) u_sync_sclk (
      .clk(clk), .rst(rst), .din(spi.spi_sclk),
      .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
   );

   spi_cmd_receiver_sync_edge_det #(.RESET_VAL(1'b1)) u_sync_cs (
      .clk(clk), .rst(rst), .din(spi.spi_cs_n),
      .level(cs_level), .rise(cs_rise), .fall(cs_fall)
   );

   spi_cmd_receiver_sync_edge_det #(.RESET_VAL(1'b0)) u_sync_mosi (
      .clk(clk), .rst(rst), .din(spi.spi_mosi),
      .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
   );

   assign opcode         = shift_reg[FRAME_BITS-1 -: 2];
   assign payload_unused = shift_reg[FRAME_BITS-3:DUTY_W];
   assign frame_ok       = (bit_cnt == CNT_FULL) && op_is_legal(opcode);
   assign commit         = (state == ST_CHECK) && frame_ok;
   assign reject         = (state == ST_CHECK) && !frame_ok;

   // Frame sequencing. WAIT_IDLE first lets the synchronizers fill with real pin samples
   // (their reset values say cs_n is high) so a frame already in flight at reset is skipped.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_WAIT_IDLE;
         settle_cnt <= 2'd0;
         shift_reg  <= '0;
         bit_cnt    <= '0;
      end else begin
         case (state)
            ST_WAIT_IDLE: begin
               if (settle_cnt != 2'd3) begin
                  settle_cnt <= settle_cnt + 2'd1;
               end else if (cs_level) begin
                  state <= ST_IDLE;
               end
            end
            ST_IDLE: begin
               if (cs_fall) begin
                  shift_reg <= '0;
                  bit_cnt   <= '0;
                  state     <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               if (cs_rise) begin
                  state <= ST_CHECK;
               end else if (sclk_rise) begin
                  shift_reg <= {shift_reg[FRAME_BITS-2:0], mosi_level};
                  if (bit_cnt != CNT_MAX) begin
                     bit_cnt <= bit_cnt + CNT_W'(1);
                  end
               end
            end
            ST_CHECK: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_WAIT_IDLE;
            end
         endcase
      end
   end

   // Decoded controls and the one-cycle result strobes, all from the CHECK cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         duty          <= '0;
         pwm_en        <= 1'b0;
         data_received <= 1'b0;
         frame_err     <= 1'b0;
      end else begin
         data_received <= commit;
         frame_err     <= reject;
         if (commit) begin
            case (opcode)
               OP_DUTY: duty   <= shift_reg[DUTY_W-1:0];
               OP_EN:   pwm_en <= shift_reg[0];
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         err_count <= '0;
      end else if (reject && (err_count != {ERR_W{1'b1}})) begin
         err_count <= err_count + ERR_W'(1);
      end
   end

   // LED stretcher: loaded alongside data_received, so the LED is high for BLINK_CYCLES clk.
   always_ff @(posedge clk) begin
      if (rst) begin
         led_rx    <= 1'b0;
         blink_cnt <= '0;
      end else if (commit) begin
         led_rx    <= 1'b1;
         blink_cnt <= BLINK_LOAD;
      end else if (blink_cnt != '0) begin
         blink_cnt <= blink_cnt - BLINK_W'(1);
      end else begin
         led_rx <= 1'b0;
      end
   end

endmodule
